// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer and transmitter signal bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  ack_error;
  logic                  tx_idle;
  logic                  uart_enable;
  logic [DATA_WIDTH-1:0] uart_data;
  logic                  uart_busy;

  modport master (
    output wr_en, wr_data, uart_busy,
    input  full, empty, count, overflow, ack_error, tx_idle, uart_enable, uart_data
  );

  modport slave (
    input  wr_en, wr_data, uart_busy,
    output full, empty, count, overflow, ack_error, tx_idle, uart_enable, uart_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO and launch sequencer feeding a UART transmitter
module uart_tx_fifo #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH       = 4,
  parameter int ACK_TIMEOUT      = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0]         TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, ACK, DRAIN} state_t;

  state_t                      state;
  logic [INPUT_DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]       wr_ptr;
  logic [ADDR_WIDTH-1:0]       rd_ptr;
  logic [ADDR_WIDTH:0]         count_q;
  logic [TW-1:0]               timer;
  logic                        overflow_q;
  logic                        ack_error_q;
  logic                        uart_enable_q;
  logic [INPUT_DATA_WIDTH-1:0] uart_data_q;

  logic full_c;
  logic empty_c;
  logic wr_accept;
  logic pop;

  // Full/empty come from the count registered at the start of the cycle,
  // so a pop in the same cycle never frees a slot for a write.
  assign full_c    = (count_q == FULL_COUNT);
  assign empty_c   = (count_q == '0);
  assign wr_accept = bus.wr_en && !full_c;
  assign pop       = (state == IDLE) && !empty_c;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.wr_en && full_c;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_accept, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      ack_error_q   <= 1'b0;
      uart_enable_q <= 1'b0;
      uart_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_data_q   <= mem[rd_ptr];
            uart_enable_q <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          uart_enable_q <= 1'b0;
          timer         <= '0;
          state         <= ACK;
        end
        ACK: begin
          // Give up once the incremented timer would reach ACK_TIMEOUT-1:
          // the error lands ACK_TIMEOUT cycles after the strobe.
          if (bus.uart_busy) begin
            state <= DRAIN;
          end else if ((timer + TIMER_ONE) == TIMER_LAST) begin
            ack_error_q <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TIMER_ONE;
          end
        end
        DRAIN: begin
          if (!bus.uart_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.ack_error   = ack_error_q;
  assign bus.tx_idle     = (state == IDLE) && empty_c;
  assign bus.uart_enable = uart_enable_q;
  assign bus.uart_data   = uart_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a queue-based reference model
module tb_uart_tx_fifo;
  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int TO    = 4;
  localparam int DEPTH = 16;

  typedef enum {M_MANUAL, M_LOOP, M_STUCK} mode_t;

  typedef struct {
    bit         we;
    logic [7:0] d;
    bit         busy;
    bit         en;
    logic [4:0] cnt;
    logic [7:0] data;
    bit         ack;
    bit         idle;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  uart_tx_fifo #(
    .INPUT_DATA_WIDTH(W),
    .ADDR_WIDTH(AW),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;

  mode_t           mode = M_MANUAL;
  bit              busy_manual = 1'b0;
  bit              rand_frames = 1'b0;
  int              frame_len = 3;
  int              frame_left = 0;
  logic [7:0]      frame_byte = 8'h00;
  byte unsigned    model_q[$];
  byte unsigned    sent_q[$];
  byte unsigned    rx_q[$];
  bit              exp_ack = 1'b0;
  bit              exp_ovf = 1'b0;
  int              ack_since = -1;
  bit              prev_en = 1'b0;
  int              max_count = 0;
  vec_t            tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_mode(input mode_t m);
    mode = m;
    frame_left = 0;
    bus.uart_busy = (m == M_STUCK);
  endtask

  // One clock: drive inputs, step the edge, then update the model and compare.
  task automatic cycle(input bit we, input logic [7:0] d);
    bit full_before;
    bit busy_at_edge;
    bit rst_at_edge;
    bus.wr_en = we;
    bus.wr_data = d;
    if (mode == M_MANUAL) bus.uart_busy = busy_manual;
    busy_at_edge = bus.uart_busy;
    rst_at_edge = reset;
    full_before = (model_q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (rst_at_edge) begin
      model_q.delete();
      exp_ack = 1'b0;
      exp_ovf = 1'b0;
      ack_since = -1;
      frame_left = 0;
      if (mode != M_MANUAL) bus.uart_busy = (mode == M_STUCK);
    end else begin
      exp_ovf = we && full_before;
      if (ack_since >= 0) begin
        ack_since++;
        if (ack_since >= 2 && busy_at_edge) ack_since = -1;
        else if (ack_since == TO) begin
          exp_ack = 1'b1;
          ack_since = -1;
        end
      end
      if (bus.uart_enable) begin
        check("enable_single_cycle", prev_en, 0);
        if (mode != M_STUCK) check("enable_while_busy", bus.uart_busy, 0);
        if (model_q.size() > 0) begin
          check("pop_data", bus.uart_data, model_q[0]);
          void'(model_q.pop_front());
        end else begin
          check("pop_from_empty", model_q.size(), 1);
        end
        ack_since = 0;
      end
      if (we && !full_before) begin
        model_q.push_back(d);
        sent_q.push_back(d);
      end
      if (mode == M_LOOP) begin
        if (frame_left > 0) begin
          check("data_stable", bus.uart_data, frame_byte);
          frame_left--;
          if (frame_left == 0) bus.uart_busy = 1'b0;
        end else if (bus.uart_enable) begin
          frame_byte = bus.uart_data;
          rx_q.push_back(frame_byte);
          frame_left = rand_frames ? int'($urandom_range(2, 6)) : frame_len;
          bus.uart_busy = 1'b1;
        end
      end
    end
    check("count", bus.count, model_q.size());
    check("full", bus.full, model_q.size() == DEPTH);
    check("empty", bus.empty, model_q.size() == 0);
    check("overflow", bus.overflow, exp_ovf);
    check("ack_error", bus.ack_error, exp_ack);
    if (int'(bus.count) > max_count) max_count = int'(bus.count);
    prev_en = bus.uart_enable;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(0, 8'h00);
    cycle(0, 8'h00);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      cycle(0, 8'h00);
      if (bus.tx_idle && model_q.size() == 0 && frame_left == 0) done = 1'b1;
    end
    check(name, done, 1);
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.uart_busy = 1'b0;

    //                we  d      busy en cnt data   ack idle
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'hA5, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'hA5, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hA5, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hA5, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'hA5, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 8'hA5, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h5A, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h5A, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h5A, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h5A, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h5A, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 8'hC3, 1'b0, 1'b0, 5'd1, 8'h5A, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'hC3, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'hC3, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'hC3, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'hC3, 1'b1, 1'b1};

    do_reset();
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_ack_error", bus.ack_error, 0);
    check("rst_tx_idle", bus.tx_idle, 1);
    check("rst_uart_enable", bus.uart_enable, 0);
    check("rst_uart_data", bus.uart_data, 0);

    // Single byte handshake, then an unacknowledged launch, then recovery.
    for (int i = 0; i < 17; i++) begin
      busy_manual = tbl[i].busy;
      cycle(tbl[i].we, tbl[i].d);
      check($sformatf("tbl%0d_enable", i), bus.uart_enable, tbl[i].en);
      check($sformatf("tbl%0d_count", i), bus.count, tbl[i].cnt);
      check($sformatf("tbl%0d_data", i), bus.uart_data, tbl[i].data);
      check($sformatf("tbl%0d_ack_error", i), bus.ack_error, tbl[i].ack);
      check($sformatf("tbl%0d_tx_idle", i), bus.tx_idle, tbl[i].idle);
    end

    // Reset while draining a frame with five bytes still queued.
    set_mode(M_LOOP);
    rand_frames = 1'b0;
    frame_len = 10;
    for (int i = 0; i < 6; i++) cycle(1, 8'(8'h10 + i));
    check("mid_count_before_reset", bus.count, 5);
    reset = 1'b1;
    cycle(0, 8'h00);
    reset = 1'b0;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_enable", bus.uart_enable, 0);
    check("mid_rst_ack_error", bus.ack_error, 0);
    check("mid_rst_tx_idle", bus.tx_idle, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 8'h00);
      check("no_stray_strobe", bus.uart_enable, 0);
    end

    // Stall the sequencer in DRAIN, fill to full, overflow once, then drain in order.
    set_mode(M_STUCK);
    do_reset();
    cycle(1, 8'hEE);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1, 8'(i));
    check("burst_full", bus.full, 1);
    check("burst_no_overflow", bus.overflow, 0);
    cycle(1, 8'h99);
    check("ovf_pulse", bus.overflow, 1);
    check("ovf_count", bus.count, 16);
    cycle(0, 8'h00);
    check("ovf_pulse_ends", bus.overflow, 0);
    rx_q.delete();
    frame_len = 3;
    set_mode(M_LOOP);
    wait_idle("burst_drain_timeout");
    check("burst_rx_len", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) check("burst_order", rx_q[i], i);

    // Random spacing across the pointer wrap with the transmitter looped back.
    do_reset();
    set_mode(M_LOOP);
    rand_frames = 1'b1;
    sent_q.delete();
    rx_q.delete();
    max_count = 0;
    for (int g = 0; g < 5000 && sent_q.size() < 40; g++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      for (int k = 0; k < gap; k++) cycle(0, 8'h00);
      cycle(1, 8'($urandom));
    end
    check("rand_all_written", sent_q.size(), 40);
    wait_idle("rand_drain_timeout");
    check("rand_rx_len", rx_q.size(), sent_q.size());
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) check("rand_order", rx_q[i], sent_q[i]);
    check("rand_max_count", max_count <= DEPTH, 1);
    check("rand_ack_error", bus.ack_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter. Producers push bytes at full clock rate; the block stores them in a circular FIFO and feeds them one at a time to the transmitter's enable/data inputs. It honours the transmitter's busy handshake and holds the data bus stable for the whole frame. Drops and handshake failures are flagged.

## Interface
- INPUT_DATA_WIDTH, 8: byte width, matches the UART data width
- ADDR_WIDTH, 4: FIFO depth = 2^ADDR_WIDTH (default 16 entries)
- ACK_TIMEOUT, 4: cycles allowed for uart_busy to rise after a launch
- clk  in  1  the design clock; everything here runs on one clock
- reset  in  1  synchronous, active-high; clears FIFO, FSM and flags
- wr_en  in  1  push wr_data this cycle
- wr_data  in  INPUT_DATA_WIDTH  byte to enqueue
- full  out  1  count == 2^ADDR_WIDTH
- empty  out  1  count == 0
- count  out  ADDR_WIDTH+1  bytes stored; excludes the byte in flight
- overflow  out  1  one-cycle pulse: a write was dropped
- ack_error  out  1  sticky: launch not acknowledged within ACK_TIMEOUT; cleared only by reset
- tx_idle  out  1  FSM in IDLE and FIFO empty
- uart_enable  out  1  one-cycle launch strobe to the transmitter's enable
- uart_data  out  INPUT_DATA_WIDTH  byte to the transmitter's data input
- uart_busy  in  1  transmitter busy (its o_busy)

## Operation
- Storage: wr_ptr and rd_ptr of ADDR_WIDTH bits wrap modulo depth. count is tracked separately: +1 on accepted write, -1 on pop, unchanged on both together.
- Write accepted iff wr_en && !full. full is taken from the registered count at the start of the cycle. A write while full is dropped and pulses overflow, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if !empty, pop at this edge: uart_data <= mem[rd_ptr], rd_ptr++, uart_enable <= 1, go LAUNCH.
  - LAUNCH: uart_enable <= 0, timer <= 0, go ACK.
  - ACK: if uart_busy, go DRAIN. Else timer++. When timer reaches ACK_TIMEOUT-1 with busy still low, set ack_error, go IDLE; the byte is lost.
  - DRAIN: wait for uart_busy == 0, then go IDLE.
- uart_data changes only on a pop edge. It is stable from launch through the whole frame, until the next pop.
- uart_enable is never high while uart_busy is high, and never high for two consecutive cycles.
- Reset mid-frame: FIFO flushed, FSM to IDLE, uart_enable low. The transmitter shares the same reset.

## Timing
- Reset values: full=0, empty=1, count=0, overflow=0, ack_error=0, tx_idle=1, uart_enable=0, uart_data=0, pointers=0, state=IDLE.
- Write at edge E0 into an empty FIFO with FSM in IDLE:
  - empty falls after E0.
  - At E1: pop; uart_enable high for cycle E1–E2; count returns to 0.
  - Write-to-strobe latency is 1 cycle.
- Back-to-back frames:
  - DRAIN samples uart_busy = 0 at edge Dn and moves to IDLE.
  - Next pop at Dn+1.
  - Minimum 1 idle cycle between busy falling and the next strobe.
- Simultaneous write and pop with count=k (k < depth): count stays k; the new byte goes to tail.
- Wrap: the 17th write after 16 pops lands at index 0; FIFO order is preserved across the wrap.
- overflow is combinationally independent of the FSM; it is registered and high for exactly the cycle after the dropped write.

## Test plan
- Single byte: write 0xA5 with the UART looped back -> one uart_enable pulse 1 cycle later; uart_data = 0xA5 held until busy falls; the receiver reports 0xA5 valid; tx_idle returns to 1.
- Burst: write 0x00..0x0F on 16 consecutive cycles -> full=1 after the 16th write; bytes transmitted in order 0x00..0x0F; no overflow.
- Overflow: with FSM stalled (uart_busy forced 1), write 17 bytes -> 17th dropped; overflow pulses once; count=16.
- Ack timeout: tie uart_busy=0 and write 0x3C -> ack_error=1 ACK_TIMEOUT cycles after the strobe; the next byte still launches; ack_error stays 1 until reset.
- Wrap and simultaneous push/pop: 40 bytes written at random spacing during transmission -> the received sequence equals the written sequence; count is never above 16.
- Reset mid-frame: assert reset while DRAIN holds 5 bytes queued -> next cycle count=0, empty=1, uart_enable=0, ack_error=0; no stray strobe after release.
